// File: rtl/vector_frame_loader_pkg.sv
// Shared definitions for the vector frame loader: default geometry, word count
// helper and the frame FSM state encoding.
package vector_frame_loader_pkg;

   localparam int DEF_VEC_W  = 1894;
   localparam int DEF_WORD_W = 32;

   // Number of stream beats needed to carry one vec_w-bit vector.
   function automatic int nwords(input int vec_w, input int word_w);
      return (vec_w + word_w - 1) / word_w;
   endfunction

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EVAL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/vector_frame_loader_sat_counter.sv
// Saturating up-counter: holds at all-ones, clear dominates increment.
module vector_frame_loader_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vector_frame_loader.sv
// Assembles WORD_W-bit stream beats into a VEC_W-bit vector, presents it for one
// cycle to an external learned bit module and scores its answer against s_exp.
module vector_frame_loader
   import vector_frame_loader_pkg::*;
#(
   parameter int VEC_W  = DEF_VEC_W,
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   input  logic              s_exp,
   input  logic              clr,
   output logic [VEC_W-1:0]  vec_o,
   output logic              vec_valid,
   input  logic              bit_i,
   output logic [31:0]       sample_cnt,
   output logic [31:0]       err_cnt,
   output logic [15:0]       frame_err_cnt,
   output state_t            fsm_state
);

   localparam int NWORDS = nwords(VEC_W, WORD_W);
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   state_t             state;
   logic [IDX_W-1:0]   word_idx;
   logic [VEC_W-1:0]   vec_r;
   logic               exp_r;
   logic               beat;
   logic               at_last;

   // A beat transfers on a rising edge where s_valid and s_ready are both high;
   // s_ready is a function of state and rst only, never of s_valid.
   assign s_ready = !rst && (state != EVAL);
   assign beat    = s_valid && s_ready;
   assign at_last = (word_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         word_idx  <= '0;
         vec_r     <= '0;
         exp_r     <= 1'b0;
         vec_valid <= 1'b0;
      end else begin
         vec_valid <= 1'b0;
         case (state)
            FILL: begin
               if (beat) begin
                  // Bit-wise write so the padding bits of the final word fall away.
                  for (int b = 0; b < VEC_W; b++) begin
                     if (IDX_W'(b / WORD_W) == word_idx) begin
                        vec_r[b] <= s_data[b % WORD_W];
                     end
                  end
                  if (at_last) begin
                     word_idx <= '0;
                     if (s_last) begin
                        exp_r     <= s_exp;
                        state     <= EVAL;
                        vec_valid <= 1'b1;
                     end else begin
                        state <= DRAIN;
                     end
                  end else if (s_last) begin
                     word_idx <= '0;
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                  end
               end
            end
            EVAL: state <= FILL;
            DRAIN: begin
               if (beat && s_last) begin
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign vec_o     = vec_r;
   assign fsm_state = state;

   logic sample_inc;
   logic err_inc;
   logic frame_err_inc;

   assign sample_inc    = (state == EVAL);
   assign err_inc       = (state == EVAL) && (bit_i != exp_r);
   assign frame_err_inc = (state == FILL) && beat && (at_last != s_last);

   vector_frame_loader_sat_counter #(.W(32)) u_sample_cnt (
      .clk (clk), .rst (rst), .inc (sample_inc), .clr (clr), .cnt (sample_cnt)
   );

   vector_frame_loader_sat_counter #(.W(32)) u_err_cnt (
      .clk (clk), .rst (rst), .inc (err_inc), .clr (clr), .cnt (err_cnt)
   );

   vector_frame_loader_sat_counter #(.W(16)) u_frame_err_cnt (
      .clk (clk), .rst (rst), .inc (frame_err_inc), .clr (clr), .cnt (frame_err_cnt)
   );

endmodule

// File: tb/tb_vector_frame_loader.sv
// Directed bench for vector_frame_loader: framing, scoring, saturation, clear
// and reset behaviour, with a queue of expected presented vectors.
module tb_vector_frame_loader;
   import vector_frame_loader_pkg::*;

   localparam int VEC_W  = 1894;
   localparam int WORD_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic              s_last;
   logic              s_exp;
   logic              clr;
   logic [VEC_W-1:0]  vec_o;
   logic              vec_valid;
   logic              bit_i;
   logic [31:0]       sample_cnt;
   logic [31:0]       err_cnt;
   logic [15:0]       frame_err_cnt;
   state_t            fsm_state;

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   vector_frame_loader #(.VEC_W(VEC_W), .WORD_W(WORD_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_last        (s_last),
      .s_exp         (s_exp),
      .clr           (clr),
      .vec_o         (vec_o),
      .vec_valid     (vec_valid),
      .bit_i         (bit_i),
      .sample_cnt    (sample_cnt),
      .err_cnt       (err_cnt),
      .frame_err_cnt (frame_err_cnt),
      .fsm_state     (fsm_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: every presented vector must match the oldest expected entry.
   always @(negedge clk) begin
      if (vec_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("vec_word0", 64'(vec_o[31:0]), 64'(e[31:0]));
            check("vec_word1", 64'(vec_o[63:32]), 64'(e[63:32]));
            check("vec_top_bits", 64'(vec_o[VEC_W-1:VEC_W-6]), 64'd59);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      clr     = 1'b0;
      idle(2);
      check("ready_in_reset", 64'(s_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 64'(s_ready), 64'd1);
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l, input logic e);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      s_exp   = e;
      n = 0;
      while (s_ready !== 1'b1 && n < 16) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (s_ready !== 1'b1) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int n_beats, input int last_at, input logic e);
      for (int k = 0; k < n_beats; k++) begin
         send_beat(32'(k), (k == last_at), e);
      end
   endtask

   // A clean 60-beat frame with word k = k; returns during the EVAL cycle.
   task automatic good_frame(input logic e, input logic b);
      bit_i = b;
      exp_q.push_back({32'd1, 32'd0});
      send_frame(60, 59, e);
      check("valid_latency", 64'(vec_valid), 64'd1);
      check("ready_low_eval", 64'(s_ready), 64'd0);
   endtask

   task automatic check_counts(input string tag, input logic [31:0] s,
                               input logic [31:0] e, input logic [15:0] f);
      check({tag, "_sample"}, 64'(sample_cnt), 64'(s));
      check({tag, "_err"}, 64'(err_cnt), 64'(e));
      check({tag, "_frame_err"}, 64'(frame_err_cnt), 64'(f));
   endtask

   initial begin
      rst     = 1'b1;
      clr     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      s_exp   = 1'b0;
      bit_i   = 1'b0;

      do_reset();
      check("reset_valid", 64'(vec_valid), 64'd0);
      check("reset_vec", 64'(vec_o[63:0]), 64'd0);
      check("reset_state", 64'(fsm_state), 64'(FILL));
      check_counts("reset", 32'd0, 32'd0, 16'd0);

      // Matching answer
      good_frame(1'b1, 1'b1);
      idle(1);
      check_counts("match", 32'd1, 32'd0, 16'd0);

      // Mismatching answer
      do_reset();
      good_frame(1'b1, 1'b0);
      idle(1);
      check_counts("mismatch", 32'd1, 32'd1, 16'd0);

      // Early s_last on beat 10, then a clean frame
      do_reset();
      bit_i = 1'b1;
      send_frame(11, 10, 1'b1);
      idle(2);
      check_counts("short", 32'd0, 32'd0, 16'd1);
      good_frame(1'b1, 1'b1);
      idle(1);
      check_counts("short_recover", 32'd1, 32'd0, 16'd1);

      // Missing s_last on beat 59, overrun drained up to beat 63
      do_reset();
      send_frame(64, 63, 1'b1);
      idle(2);
      check_counts("long", 32'd0, 32'd0, 16'd1);
      check("drain_no_write", 64'(vec_o[31:0]), 64'd0);
      good_frame(1'b1, 1'b1);
      idle(1);
      check_counts("long_recover", 32'd1, 32'd0, 16'd1);

      // Saturation of err_cnt, then clr coincident with EVAL
      do_reset();
      force dut.u_err_cnt.cnt_q = 32'hFFFF_FFFF;
      #2;
      release dut.u_err_cnt.cnt_q;
      #1;
      check("err_preload", 64'(err_cnt), 64'hFFFF_FFFF);
      good_frame(1'b1, 1'b0);
      idle(1);
      check_counts("saturate", 32'd1, 32'hFFFF_FFFF, 16'd0);
      good_frame(1'b1, 1'b0);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      check_counts("clr_wins", 32'd0, 32'd0, 16'd0);

      // Reset mid-frame after beat 30
      do_reset();
      bit_i = 1'b1;
      send_frame(31, -1, 1'b1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(2);
      check("mid_rst_valid", 64'(vec_valid), 64'd0);
      check_counts("mid_rst", 32'd0, 32'd0, 16'd0);
      good_frame(1'b1, 1'b1);
      idle(1);
      check_counts("mid_rst_recover", 32'd1, 32'd0, 16'd0);

      // Reset during EVAL abandons the scoring
      do_reset();
      good_frame(1'b1, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(1);
      check_counts("eval_rst", 32'd0, 32'd0, 16'd0);

      idle(2);
      check("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vector_frame_loader.md
VECTOR_FRAME_LOADER -- requirements
Module: vector_frame_loader

Interface
REQ-001 SHALL have parameter VEC_W, default 1894, giving the width of the assembled input vector.
REQ-002 SHALL have parameter WORD_W, default 32, giving the stream beat width; NWORDS = ceil(VEC_W/WORD_W), which is 60 at the defaults.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1 bit: a stream beat is offered.
REQ-006 SHALL have port s_ready, output, 1 bit: the block accepts the beat.
REQ-007 SHALL have port s_data, input, WORD_W bits: vector bits [k*WORD_W +: WORD_W] for word index k.
REQ-008 SHALL have port s_last, input, 1 bit: marks the final beat of a frame.
REQ-009 SHALL have port s_exp, input, 1 bit: expected output bit, sampled on the s_last beat only.
REQ-010 SHALL have port clr, input, 1 bit: synchronous clear of all counters.
REQ-011 SHALL have port vec_o, output, VEC_W bits: registered vector driving the i port of a learned output-bit module.
REQ-012 SHALL have port vec_valid, output, 1 bit: vec_o holds a complete frame this cycle.
REQ-013 SHALL have port bit_i, input, 1 bit: combinational o returned by the learned module for vec_o.
REQ-014 SHALL have ports sample_cnt (32 bits), err_cnt (32 bits) and frame_err_cnt (16 bits), all outputs.

Function
REQ-015 SHALL implement three FSM states: FILL, EVAL and DRAIN.
REQ-016 FILL: s_ready=1; each handshake (s_valid&s_ready) writes s_data into vec_r word word_idx and increments word_idx.
REQ-017 Bits of the last word above VEC_W-1 SHALL be discarded; at the defaults only bits [5:0] of word 59 are kept.
REQ-018 FILL, beat with word_idx==NWORDS-1 and s_last=1: SHALL register s_exp into exp_r, reset word_idx to 0 and go to EVAL.
REQ-019 FILL, beat with word_idx==NWORDS-1 and s_last=0: SHALL increment frame_err_cnt, reset word_idx to 0 and go to DRAIN.
REQ-020 FILL, beat with word_idx<NWORDS-1 and s_last=1: SHALL increment frame_err_cnt, reset word_idx to 0, stay in FILL and raise no vec_valid.
REQ-021 EVAL lasts exactly 1 cycle, with s_ready=0 and vec_valid=1; it SHALL increment sample_cnt, increment err_cnt if bit_i!=exp_r, then return to FILL.
REQ-022 DRAIN: s_ready=1; beats are discarded without writing vec_r; a beat with s_last=1 returns the FSM to FILL.
REQ-023 Latency: vec_valid SHALL assert the cycle after the s_last handshake; counters update at the end of that cycle.
REQ-024 Minimum frame period SHALL be NWORDS+1 cycles.
REQ-025 All counters SHALL saturate at all-ones and never wrap.
REQ-026 clr together with an EVAL increment: clr SHALL win, leaving the counter at 0.
REQ-027 vec_o SHALL equal vec_r; it is meaningful only while vec_valid=1, and partial overwrite during FILL is permitted.
REQ-028 s_ready SHALL NOT depend combinationally on s_valid.

Reset
REQ-029 On rst=1 at a clock edge: state=FILL, word_idx=0, vec_r=0, exp_r=0, all counters=0, vec_valid=0.
REQ-030 s_ready SHALL be 0 while rst=1 and 1 in the cycle after rst deasserts.
REQ-031 rst asserted mid-frame or in EVAL SHALL abandon the frame with no counter update.

Structure
REQ-032 A shared package SHALL hold VEC_W, WORD_W, the NWORDS function and the FSM state enum.
REQ-033 One natural sub-module is sat_counter (parameterized width, inc, clr, saturating), instantiated three times.
REQ-034 The learned module SHALL be instantiated by the bench or top level, not inside this block.

Verification
REQ-035 Stream 60 beats, word k = k, s_last on beat 59, s_exp=1, bit_i tied 1 -> vec_valid pulses one cycle later; vec_o[31:0]=0, vec_o[63:32]=1; sample_cnt=1, err_cnt=0.
REQ-036 Same frame with bit_i tied 0 -> err_cnt=1, sample_cnt=1.
REQ-037 s_last on beat 10 -> frame_err_cnt=1, no vec_valid; the next clean 60-beat frame evaluates normally.
REQ-038 No s_last on beat 59, s_last on beat 63 -> frame_err_cnt=1, beats 60..63 discarded; the next clean frame gives sample_cnt=1.
REQ-039 Preload err_cnt to 0xFFFFFFFF via force, then run a mismatching frame -> err_cnt stays 0xFFFFFFFF; clr coincident with EVAL -> all counters 0.
REQ-040 rst pulse after beat 30 -> no vec_valid; a following 60-beat frame yields sample_cnt=1.
